uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched_pkg.sv | 6 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/uart_tx_sched.sv | 77 +++++++
 tb/tb_uart_tx_sched.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg: shared state encoding and frame constants for uart_tx_sched.
package uart_tx_sched_pkg;
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  localparam int FRAME_BITS = 11;
  localparam int BAUD_DEFAULT = 115200;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap.
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);
  logic found;
  int k;
  always_comb begin
    gnt = '0;
    idx = '0;
    found = 1'b0;
    k = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!found && req[k]) begin
        found = 1'b1;
        gnt[k] = 1'b1;
        idx = W'(k);
      end
    end
  end
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin byte scheduler for a UART TX that has no busy flag.
// Define UART_TX_SCHED_LOCK_EN to let a requester keep the grant across bytes.
module uart_tx_sched import uart_tx_sched_pkg::*; #(
  parameter int FREQ = 27000000,
  parameter int BAUD = BAUD_DEFAULT,
  parameter int NREQ = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [8*NREQ-1:0]       req_data_i,
  input  logic [NREQ-1:0]         req_lock_i,
  output logic [NREQ-1:0]         req_ready_o,
  output logic                    uart_write_o,
  output logic [7:0]              uart_val_o,
  output logic                    busy_o,
  output logic [$clog2(NREQ)-1:0] grant_o
);
  localparam int IW = $clog2(NREQ);
  localparam int BIT_CYCLES = FREQ / BAUD;
  localparam int GAP_CYCLES = FRAME_BITS * BIT_CYCLES;
  localparam int CW = $clog2(GAP_CYCLES) + 1;
  state_t state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] ptr, idx;
  logic [NREQ-1:0] req, gnt;
  logic hs, gap_end;
`ifdef UART_TX_SCHED_LOCK_EN
  logic lock;
  logic [IW-1:0] lock_idx;
  // A held lock masks everyone but the owner; the owner dropping valid in IDLE frees it.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      lock <= 1'b0;
      lock_idx <= '0;
    end else if (hs) begin
      lock <= req_lock_i[idx];
      lock_idx <= idx;
    end else if (state == IDLE && !req_valid_i[lock_idx])
      lock <= 1'b0;
  assign req = lock ? req_valid_i & (NREQ'(1) << lock_idx) : req_valid_i;
`else
  logic unused_lock;
  assign unused_lock = ^req_lock_i;
  assign req = req_valid_i;
`endif
  rr_arbiter #(.N(NREQ)) u_arb (.req(req), .ptr(ptr), .gnt(gnt), .idx(idx));
  assign req_ready_o = state == IDLE ? gnt : '0;
  assign hs = state == IDLE && |gnt;
  assign busy_o = state != IDLE;
  assign gap_end = cnt == CW'(GAP_CYCLES - 2);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= '0;
      uart_write_o <= 1'b0;
      uart_val_o <= '0;
      grant_o <= '0;
    end else begin
      uart_write_o <= hs;
      case (state)
        IDLE: if (hs) begin
          state <= SEND;
          uart_val_o <= req_data_i[8*idx +: 8];
          grant_o <= idx;
          ptr <= idx == IW'(NREQ - 1) ? '0 : idx + 1'b1;
        end
        SEND: state <= GAP;
        GAP: begin
          state <= gap_end ? IDLE : GAP;
          cnt <= gap_end ? '0 : cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: queued requester driver plus scoreboard monitor on the UART strobe.
module tb_uart_tx_sched;
  typedef struct {
    logic [1:0] g;
    logic [7:0] d;
    int gap;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] valid = '0, lock = '0, ready;
  logic [31:0] data = '0;
  logic write, busy;
  logic [7:0] val;
  logic [1:0] grant;
  logic [7:0] pend_d [4][$];
  logic pend_l [4][$];
  logic [3:0] hs_v = '0;
  exp_t exp_q[$];
  exp_t mon_e;
  int cyc = 0, last_s = 0, n_chk = 0, n_fail = 0;

  uart_tx_sched #(.FREQ(1152000), .BAUD(115200), .NREQ(4)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_data_i(data), .req_lock_i(lock),
    .req_ready_o(ready), .uart_write_o(write), .uart_val_o(val), .busy_o(busy), .grant_o(grant)
  );

  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic stim(input int k, input logic [7:0] d, input logic l);
    pend_d[k].push_back(d);
    pend_l[k].push_back(l);
  endtask

  task automatic exp_push(input logic [1:0] g, input logic [7:0] d, input int gap);
    exp_t e;
    e.g = g;
    e.d = d;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  function automatic int pend_total();
    int s = 0;
    for (int k = 0; k < 4; k++) s += pend_d[k].size();
    return s;
  endfunction

  task automatic wait_q(input string name, input int n);
    int t = 0;
    while (exp_q.size() > n && t < 1000) begin
      @(negedge clk);
      #2;
      t++;
    end
    check(name, t < 1000, 1);
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || busy || pend_total() != 0) && t < 2000) begin
      @(negedge clk);
      #2;
      t++;
    end
    check(name, t < 2000, 1);
  endtask

  // Requester model: pops a byte the negedge after its handshake edge.
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 4; k++)
      if (hs_v[k]) begin
        void'(pend_d[k].pop_front());
        void'(pend_l[k].pop_front());
      end
    for (int k = 0; k < 4; k++) begin
      valid[k] = pend_d[k].size() != 0;
      data[8*k +: 8] = valid[k] ? pend_d[k][0] : 8'h00;
      lock[k] = valid[k] ? pend_l[k][0] : 1'b0;
    end
    #1 hs_v = rst ? 4'b0 : valid & ready;
  end

  initial forever begin
    @(negedge clk);
    if (!rst && write) begin
      check("strobe_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("strobe_grant", grant, mon_e.g);
        check("strobe_data", val, mon_e.d);
        if (mon_e.gap != 0) check("strobe_spacing", cyc - last_s, mon_e.gap);
      end
      last_s = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int t0, bad;
    repeat (2) @(negedge clk);
    #2;
    check("rst_busy", busy, 0);
    check("rst_write", write, 0);
    check("rst_val", val, 0);
    check("rst_grant", grant, 0);
    check("rst_ready", ready, 0);
    rst = 1'b0;
    // fairness from pointer 0
    stim(0, 8'hA0, 0); stim(1, 8'hB1, 0); stim(2, 8'hC2, 0); stim(3, 8'hD3, 0); stim(0, 8'hA4, 0);
    exp_push(0, 8'hA0, 0); exp_push(1, 8'hB1, 111); exp_push(2, 8'hC2, 111);
    exp_push(3, 8'hD3, 111); exp_push(0, 8'hA4, 111);
    wait_done("fair_done");
    // lock: pointer is 1 here so requester 1 wins the first pick
    stim(1, 8'h11, 1); stim(1, 8'h12, 1); stim(1, 8'h13, 0); stim(0, 8'h01, 0); stim(0, 8'h02, 0);
`ifdef UART_TX_SCHED_LOCK_EN
    exp_push(1, 8'h11, 0); exp_push(1, 8'h12, 111); exp_push(1, 8'h13, 111);
    exp_push(0, 8'h01, 111); exp_push(0, 8'h02, 111);
`else
    exp_push(1, 8'h11, 0); exp_push(0, 8'h01, 111); exp_push(1, 8'h12, 111);
    exp_push(0, 8'h02, 111); exp_push(1, 8'h13, 111);
`endif
    wait_done("lock_done");
    // reset mid-gap after a grant to 2 (pointer 3)
    stim(2, 8'h77, 0);
    exp_push(2, 8'h77, 0);
    wait_q("mid_strobe", 0);
    repeat (51) @(negedge clk);
    #2;
    check("mid_busy_before", busy, 1);
    check("mid_val_before", val, 8'h77);
    rst = 1'b1;
    #1;
    check("mid_busy", busy, 0);
    check("mid_write", write, 0);
    check("mid_val", val, 0);
    check("mid_grant", grant, 0);
    check("mid_ready", ready, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    stim(0, 8'h31, 0); stim(3, 8'h32, 0);
    exp_push(0, 8'h31, 0); exp_push(3, 8'h32, 111);
    @(negedge clk);
    #2 check("post_rst_ready", ready, 4'b0001);
    wait_done("post_rst_done");
    // single byte timing
    stim(2, 8'hA5, 0);
    exp_push(2, 8'hA5, 0);
    @(negedge clk);
    #2 t0 = cyc;
    check("single_ready", ready, 4'b0100);
    @(negedge clk);
    #2 check("single_write_t1", write, 1);
    check("single_cycle", cyc - t0, 1);
    @(negedge clk);
    #2 check("single_write_t2", write, 0);
    repeat (108) @(negedge clk);
    #2 check("single_busy_t110", busy, 1);
    @(negedge clk);
    #2 check("single_busy_t111", busy, 0);
    wait_done("single_done");
    // pointer wrap: grant 3, then 0 and 3 contend
    stim(3, 8'h3C, 0);
    exp_push(3, 8'h3C, 0); exp_push(0, 8'h0D, 111); exp_push(3, 8'h3E, 111);
    wait_q("wrap_first", 2);
    stim(0, 8'h0D, 0); stim(3, 8'h3E, 0);
    wait_done("wrap_done");
    // backpressure: second byte raised during GAP
    stim(1, 8'h5A, 0);
    exp_push(1, 8'h5A, 0); exp_push(1, 8'h6B, 111);
    wait_q("bp_first", 1);
    repeat (5) @(negedge clk);
    #2 stim(1, 8'h6B, 0);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #2;
      if (!busy) break;
      if (ready != 4'b0) bad++;
    end
    check("bp_no_ready_gap", bad, 0);
    check("bp_ready_idle", ready, 4'b0010);
    wait_done("bp_done");
    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
